sfx_scheduler: RTL

- Shares the stereo tone outputs (freqL/freqR feeding the note generator) between the selected BGM pair and up to four one-shot sound effects (hit, pickup, door, warning).
- Latches SFX requests from game logic, arbitrates by fixed priority, and plays a 4-note sequence from a note ROM while the BGM is ducked.
- Sits between game_sound and the note generator; honours mute.

---
 rtl/sfx_pkg.sv | 40 ++++
 rtl/sfx_rom.sv | 49 ++++
 rtl/sfx_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// Shared constants for the SFX scheduler: silence code, FSM encoding,
// effect ids and the 4-note tone table of each effect.
package sfx_pkg;

  localparam logic [25:0] SILENCE = 26'd50000000;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SFX_HIT    = 2'd0,
    SFX_PICKUP = 2'd1,
    SFX_DOOR   = 2'd2,
    SFX_WARN   = 2'd3
  } sfx_id_e;

  // hit: falling arpeggio ending in a rest
  localparam logic [25:0] HIT_N0    = 26'd1047;
  localparam logic [25:0] HIT_N1    = 26'd784;
  localparam logic [25:0] HIT_N2    = 26'd523;
  localparam logic [25:0] HIT_N3    = SILENCE;
  // pickup: rising arpeggio
  localparam logic [25:0] PICKUP_N0 = 26'd523;
  localparam logic [25:0] PICKUP_N1 = 26'd659;
  localparam logic [25:0] PICKUP_N2 = 26'd784;
  localparam logic [25:0] PICKUP_N3 = 26'd1047;
  // door: low creak with a gap
  localparam logic [25:0] DOOR_N0   = 26'd262;
  localparam logic [25:0] DOOR_N1   = 26'd196;
  localparam logic [25:0] DOOR_N2   = SILENCE;
  localparam logic [25:0] DOOR_N3   = 26'd131;
  // warn: beep-rest-beep-rest
  localparam logic [25:0] WARN_N0   = 26'd880;
  localparam logic [25:0] WARN_N1   = SILENCE;
  localparam logic [25:0] WARN_N2   = 26'd880;
  localparam logic [25:0] WARN_N3   = SILENCE;

endpackage

// File: rtl/sfx_rom.sv
// Combinational note table: (effect id, note index) -> 26-bit tone.
module sfx_rom
  import sfx_pkg::*;
(
  input  logic [1:0]  id_i,
  input  logic [1:0]  note_idx_i,
  output logic [25:0] tone_o
);

  // Flat 16-entry lookup; every combination is covered.
  always_comb begin
    tone_o = SILENCE;
    case (sfx_id_e'(id_i))
      SFX_HIT: begin
        case (note_idx_i)
          2'd0:    tone_o = HIT_N0;
          2'd1:    tone_o = HIT_N1;
          2'd2:    tone_o = HIT_N2;
          default: tone_o = HIT_N3;
        endcase
      end
      SFX_PICKUP: begin
        case (note_idx_i)
          2'd0:    tone_o = PICKUP_N0;
          2'd1:    tone_o = PICKUP_N1;
          2'd2:    tone_o = PICKUP_N2;
          default: tone_o = PICKUP_N3;
        endcase
      end
      SFX_DOOR: begin
        case (note_idx_i)
          2'd0:    tone_o = DOOR_N0;
          2'd1:    tone_o = DOOR_N1;
          2'd2:    tone_o = DOOR_N2;
          default: tone_o = DOOR_N3;
        endcase
      end
      default: begin
        case (note_idx_i)
          2'd0:    tone_o = WARN_N0;
          2'd1:    tone_o = WARN_N1;
          2'd2:    tone_o = WARN_N2;
          default: tone_o = WARN_N3;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Shares the stereo tone outputs between the BGM pair and one-shot sound
// effects. Requests are edge-latched, granted by fixed priority (index 0
// highest, which may preempt a lower-priority effect) and played as a
// 4-note sequence while the BGM is ducked.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int TICK_DIV = 2500000,
  parameter int NOTE_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mute,
  input  logic [N_REQ-1:0]  req,
  input  logic [25:0]       bgm_l,
  input  logic [25:0]       bgm_r,
  output logic [25:0]       freqL,
  output logic [25:0]       freqR,
  output logic              busy,
  output logic [1:0]        cur_id,
  output logic              sfx_done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int NW = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_LEN - 1);

  logic [N_REQ-1:0] req_d_q;
  logic [N_REQ-1:0] req_rise;
  logic [N_REQ-1:0] pend_q, pend_d, pend_clr;
  logic [TW-1:0]    tick_cnt_q;
  logic             tick;
  state_e           state_q, state_d;
  logic [1:0]       cur_id_q, cur_id_d;
  logic [1:0]       note_idx_q, note_idx_d;
  logic [NW-1:0]    note_ticks_q, note_ticks_d;
  logic             done_d, sfx_done_q;
  logic [25:0]      freq_l_q, freq_r_q;
  logic [25:0]      rom_tone;
  logic             grant_vld, take_grant;
  logic [1:0]       grant_idx;

  // A rising request level is one request; a new set beats a grant clear.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pend
    assign req_rise[gi] = req[gi] & ~req_d_q[gi];
    assign pend_d[gi]   = (pend_q[gi] & ~pend_clr[gi]) | req_rise[gi];
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  // Fixed-priority encoder: lowest pending index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_vld = 1'b1;
        grant_idx = 2'(i);
      end
    end
  end

  // Grant when idle, or preempt when a strictly higher priority is pending.
  assign take_grant = grant_vld &&
                      ((state_q == IDLE) || (grant_idx < cur_id_q));

  // Next-state logic: grant/preempt first, otherwise advance on ticks.
  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    note_idx_d   = note_idx_q;
    note_ticks_d = note_ticks_q;
    pend_clr     = '0;
    done_d       = 1'b0;
    if (take_grant) begin
      state_d      = PLAY;
      cur_id_d     = grant_idx;
      note_idx_d   = 2'd0;
      note_ticks_d = '0;
      pend_clr     = N_REQ'(1) << grant_idx;
    end else if ((state_q == PLAY) && tick) begin
      if (note_ticks_q == NOTE_LAST) begin
        note_ticks_d = '0;
        note_idx_d   = note_idx_q + 2'd1;
        if (note_idx_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end else begin
        note_ticks_d = note_ticks_q + NW'(1);
      end
    end
  end

  sfx_rom u_rom (
    .id_i       (cur_id_q),
    .note_idx_i (note_idx_q),
    .tone_o     (rom_tone)
  );

  // Request edge capture, pending set and free-running tick divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_d_q    <= '0;
      pend_q     <= '0;
      tick_cnt_q <= '0;
    end else begin
      req_d_q    <= req;
      pend_q     <= pend_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
    end
  end

  // FSM state and sequencing registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_id_q     <= 2'd0;
      note_idx_q   <= 2'd0;
      note_ticks_q <= '0;
      sfx_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      note_idx_q   <= note_idx_d;
      note_ticks_q <= note_ticks_d;
      sfx_done_q   <= done_d;
    end
  end

  // Registered tone mux: mute overrides, an active effect ducks the BGM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freq_l_q <= SILENCE;
      freq_r_q <= SILENCE;
    end else if (mute) begin
      freq_l_q <= SILENCE;
      freq_r_q <= SILENCE;
    end else if (state_q == PLAY) begin
      freq_l_q <= rom_tone;
      freq_r_q <= rom_tone;
    end else begin
      freq_l_q <= bgm_l;
      freq_r_q <= bgm_r;
    end
  end

  assign freqL    = freq_l_q;
  assign freqR    = freq_r_q;
  assign busy     = (state_q == PLAY);
  assign cur_id   = cur_id_q;
  assign sfx_done = sfx_done_q;

endmodule
